pipeline_stall_controller: RTL

- Central stall/flush controller for the 5-stage int/float CPU core. Sits directly downstream of the hazard detection unit and consumes its load-use signal.
- Merges that signal with branch redirects, multi-cycle EX operations (div/fdiv/fsqrt) and memory wait states.
- Drives the PC and IF/ID, ID/EX, EX/MEM, MEM/WB register write-enables, flushes and bubbles.
- Keeps an FSM for multi-cycle waits, a watchdog, and saturating performance counters.

---
 rtl/pipeline_stall_controller_pkg.sv | 46 ++++
 rtl/pipeline_stall_controller_sat_counter.sv | 24 ++
 rtl/pipeline_stall_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states, stall
// causes and the per-cause stage control patterns.
package pipeline_stall_controller_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } ctl_state_t;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        DMEM   = 3'd1,
        MC     = 3'd2,
        BRANCH = 3'd3,
        LU     = 3'd4,
        IMEM   = 3'd5
    } stall_cause_t;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_bubble;
        logic ex_mem_we;
        logic ex_mem_bubble;
        logic mem_wb_we;
    } stage_ctl_t;

    // Held while RESET is high: nothing writes, front stages are squashed.
    localparam stage_ctl_t RESET_CTL = stage_ctl_t'(8'b0010_1010);

    function automatic stage_ctl_t cause_to_ctl(input stall_cause_t cause);
        stage_ctl_t ctl;
        case (cause)
            DMEM:    ctl = stage_ctl_t'(8'b0000_0000);
            MC:      ctl = stage_ctl_t'(8'b0000_0111);
            BRANCH:  ctl = stage_ctl_t'(8'b1111_1101);
            LU:      ctl = stage_ctl_t'(8'b0001_1101);
            IMEM:    ctl = stage_ctl_t'(8'b0001_1101);
            default: ctl = stage_ctl_t'(8'b1101_0101);
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import pipeline_stall_controller_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLR,
    input  logic             INC,
    output logic [WIDTH-1:0] COUNT
);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            COUNT <= '0;
        end else if (CLR) begin
            COUNT <= '0;
        end else if (INC && (COUNT != '1)) begin
            COUNT <= COUNT + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush controller: merges load-use, branch, multi-cycle EX and
// memory-wait conditions into per-stage write-enables, flushes and bubbles.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int MC_TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 LU_HAZ_SIG,
    input  logic                 BRANCH_TAKEN,
    input  logic                 EX_MC_START,
    input  logic                 EX_MC_DONE,
    input  logic                 INSTR_MEM_BUSY,
    input  logic                 DATA_MEM_BUSY,
    input  logic                 CNT_CLEAR,
    output logic                 PC_WRITE_EN,
    output logic                 IF_ID_WRITE_EN,
    output logic                 IF_ID_FLUSH,
    output logic                 ID_EX_WRITE_EN,
    output logic                 ID_EX_BUBBLE,
    output logic                 EX_MEM_WRITE_EN,
    output logic                 EX_MEM_BUBBLE,
    output logic                 MEM_WB_WRITE_EN,
    output logic                 MC_TIMEOUT_ERR,
    output logic [CNT_WIDTH-1:0] STALL_CYCLES,
    output logic [CNT_WIDTH-1:0] FLUSH_COUNT,
    output logic [CNT_WIDTH-1:0] LU_BUBBLE_COUNT
);

    localparam int WD_W = $clog2(MC_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

    ctl_state_t      state, state_next;
    logic            done_seen, done_seen_next;
    logic [WD_W-1:0] wd_cnt, wd_cnt_next;
    logic            timeout_err, timeout_err_next;

    stall_cause_t    cause;
    stage_ctl_t      ctl;
    logic            mc_release;
    logic            mc_stall;

    // A DONE that arrived during a memory freeze is remembered in done_seen.
    assign mc_release = EX_MC_DONE || done_seen;
    assign mc_stall   = (state == MC_WAIT) ? !mc_release
                                           : (EX_MC_START && !EX_MC_DONE);

    always_comb begin
        cause = NONE;
        if (DATA_MEM_BUSY) begin
            cause = DMEM;
        end else if (mc_stall) begin
            cause = MC;
        end else if (BRANCH_TAKEN) begin
            cause = BRANCH;
        end else if (LU_HAZ_SIG) begin
            cause = LU;
        end else if (INSTR_MEM_BUSY) begin
            cause = IMEM;
        end
    end

    always_comb begin
        ctl = cause_to_ctl(cause);
        if (RESET) begin
            ctl = RESET_CTL;
        end
    end

    assign PC_WRITE_EN     = ctl.pc_we;
    assign IF_ID_WRITE_EN  = ctl.if_id_we;
    assign IF_ID_FLUSH     = ctl.if_id_flush;
    assign ID_EX_WRITE_EN  = ctl.id_ex_we;
    assign ID_EX_BUBBLE    = ctl.id_ex_bubble;
    assign EX_MEM_WRITE_EN = ctl.ex_mem_we;
    assign EX_MEM_BUBBLE   = ctl.ex_mem_bubble;
    assign MEM_WB_WRITE_EN = ctl.mem_wb_we;
    assign MC_TIMEOUT_ERR  = timeout_err;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= RUN;
            done_seen   <= 1'b0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            done_seen   <= done_seen_next;
            wd_cnt      <= wd_cnt_next;
            timeout_err <= timeout_err_next;
        end
    end

    always_comb begin
        state_next       = state;
        done_seen_next   = done_seen;
        wd_cnt_next      = wd_cnt;
        timeout_err_next = timeout_err;
        case (state)
            RUN: begin
                if (EX_MC_START && !EX_MC_DONE && !DATA_MEM_BUSY) begin
                    state_next     = MC_WAIT;
                    wd_cnt_next    = '0;
                    done_seen_next = 1'b0;
                end
            end
            MC_WAIT: begin
                if (mc_release && !DATA_MEM_BUSY) begin
                    state_next     = RUN;
                    done_seen_next = 1'b0;
                end else if (wd_cnt == WD_LAST) begin
                    // Watchdog: this is the MC_TIMEOUT-th cycle spent waiting.
                    state_next       = RUN;
                    done_seen_next   = 1'b0;
                    timeout_err_next = 1'b1;
                end else begin
                    wd_cnt_next = wd_cnt + WD_W'(1);
                    if (EX_MC_DONE) begin
                        done_seen_next = 1'b1;
                    end
                end
            end
            default: state_next = RUN;
        endcase
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .CLR   (CNT_CLEAR),
        .INC   (!ctl.pc_we),
        .COUNT (STALL_CYCLES)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .CLR   (CNT_CLEAR),
        .INC   (cause == BRANCH),
        .COUNT (FLUSH_COUNT)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_lu_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .CLR   (CNT_CLEAR),
        .INC   (cause == LU),
        .COUNT (LU_BUBBLE_COUNT)
    );

endmodule
